// File: rtl/cgp_fitness_sequencer_pkg.sv
// Shared types and defaults for the CGP fitness evaluator.
// Holds the FSM state encoding, default sizing and the settle-counter width helper.
package cgp_eval_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_N_IN          = 4;
  localparam int DEF_SETTLE_CYCLES = 2;

  // 4-input parity truth table, handy as a known-good target
  localparam logic [15:0] PARITY4_TT = 16'h6996;

  // settle_cnt only counts 0..settle_cycles-1, but keep at least one bit
  function automatic int settle_cnt_w(input int settle_cycles);
    return (settle_cycles <= 2) ? 1 : $clog2(settle_cycles);
  endfunction

endpackage

// File: rtl/cgp_fitness_sequencer_if.sv
// Evaluator <-> controller/candidate bundle: start/done handshake, target table, candidate pins, results.
// master = evolution controller plus candidate circuit; slave = the fitness sequencer.
interface cgp_fitness_sequencer_if import cgp_eval_pkg::*; #(
  parameter int N_IN = DEF_N_IN
);
  logic                   start;
  logic [(1<<N_IN)-1:0]   target_tt;
  logic [N_IN-1:0]        cand_in;
  logic                   cand_out;
  logic                   busy;
  logic                   done;
  logic [N_IN:0]          match_count;
  logic [N_IN:0]          fitness;
  logic                   perfect;

  modport master (
    output start, target_tt, cand_out,
    input  cand_in, busy, done, match_count, fitness, perfect
  );

  modport slave (
    input  start, target_tt, cand_out,
    output cand_in, busy, done, match_count, fitness, perfect
  );
endinterface

// File: rtl/cgp_fitness_sequencer_score.sv
// Combinational score mapping: mismatches -> match_count, fitness, perfect.
// A half score carries no information (random guess), so its fitness is forced to zero.
module cgp_fitness_score import cgp_eval_pkg::*; #(
  parameter int N_IN = DEF_N_IN
) (
  input  logic [N_IN:0] mismatches_i,
  output logic [N_IN:0] match_count_o,
  output logic [N_IN:0] fitness_o,
  output logic          perfect_o
);
  localparam logic [N_IN:0] FULL = (N_IN+1)'(1) << N_IN;
  localparam logic [N_IN:0] HALF = FULL >> 1;

  assign match_count_o = FULL - mismatches_i;
  assign fitness_o     = (match_count_o == HALF) ? '0 : match_count_o;
  assign perfect_o     = (match_count_o == FULL);
endmodule

// File: rtl/cgp_fitness_sequencer.sv
// Sweeps all 2^N_IN patterns into a candidate, holds each SETTLE_CYCLES before sampling against a latched table.
// done pulses 2^N_IN*(SETTLE_CYCLES+1) cycles after start; start outside IDLE is dropped, not queued.
module cgp_fitness_sequencer import cgp_eval_pkg::*; #(
  parameter int N_IN          = DEF_N_IN,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cgp_fitness_sequencer_if.slave  eval_if
);
  localparam int                NPAT     = 1 << N_IN;
  localparam int                CNT_W    = settle_cnt_w(SETTLE_CYCLES);
  localparam logic [N_IN-1:0]   IDX_LAST = N_IN'(NPAT - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state_q;
  logic [NPAT-1:0]   target_q;
  logic [N_IN-1:0]   idx_q;
  logic [CNT_W-1:0]  settle_cnt_q;
  logic [N_IN:0]     mism_q, mism_d;
  logic              busy_q, done_q, perfect_q;
  logic [N_IN:0]     match_q, fitness_q;
  logic [N_IN:0]     match_d, fitness_d;
  logic              perfect_d;
  logic              miss;

  // Case inequality so an undriven or X candidate output scores as a miss
  assign miss   = (eval_if.cand_out !== target_q[idx_q]);
  assign mism_d = mism_q + (N_IN+1)'(miss);

  // Fed from the post-sample count so results land together with done
  cgp_fitness_score #(.N_IN(N_IN)) u_score (
    .mismatches_i  (mism_d),
    .match_count_o (match_d),
    .fitness_o     (fitness_d),
    .perfect_o     (perfect_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      target_q     <= '0;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      mism_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      match_q      <= '0;
      fitness_q    <= '0;
      perfect_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (eval_if.start) begin
            target_q     <= eval_if.target_tt;
            idx_q        <= '0;
            settle_cnt_q <= '0;
            mism_q       <= '0;
            busy_q       <= 1'b1;
            match_q      <= '0;
            fitness_q    <= '0;
            perfect_q    <= 1'b0;
            state_q      <= SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt_q <= settle_cnt_q + CNT_W'(1);
          if (settle_cnt_q == CNT_LAST) state_q <= SAMPLE;
        end
        SAMPLE: begin
          mism_q <= mism_d;
          if (idx_q == IDX_LAST) begin
            match_q   <= match_d;
            fitness_q <= fitness_d;
            perfect_q <= perfect_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            idx_q        <= idx_q + N_IN'(1);
            settle_cnt_q <= '0;
            state_q      <= SETTLE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // idx_q is the pattern register; it only moves on start and SAMPLE->SETTLE
  assign eval_if.cand_in     = idx_q;
  assign eval_if.busy        = busy_q;
  assign eval_if.done        = done_q;
  assign eval_if.match_count = match_q;
  assign eval_if.fitness     = fitness_q;
  assign eval_if.perfect     = perfect_q;
endmodule

// File: tb/tb_cgp_fitness_sequencer.sv
// Directed bench for cgp_fitness_sequencer: default instance plus SETTLE_CYCLES=1 and =3 instances
// driving 1-cycle-delayed candidates.
module tb_cgp_fitness_sequencer;
  logic        clk;
  logic        rst_n;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cand_sel = 0;
  logic        cand0;
  logic        d1, d3;

  cgp_fitness_sequencer_if #(.N_IN(4)) bus  ();
  cgp_fitness_sequencer_if #(.N_IN(4)) bus1 ();
  cgp_fitness_sequencer_if #(.N_IN(4)) bus3 ();

  cgp_fitness_sequencer #(.N_IN(4), .SETTLE_CYCLES(2)) u_dut    (.clk(clk), .rst_n(rst_n), .eval_if(bus));
  cgp_fitness_sequencer #(.N_IN(4), .SETTLE_CYCLES(1)) u_dut_s1 (.clk(clk), .rst_n(rst_n), .eval_if(bus1));
  cgp_fitness_sequencer #(.N_IN(4), .SETTLE_CYCLES(3)) u_dut_s3 (.clk(clk), .rst_n(rst_n), .eval_if(bus3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Candidate models: 0 XOR4, 1 const 0, 2 XNOR4, 3 AND4
  always_comb begin
    cand0 = 1'b0;
    case (cand_sel)
      0: cand0 = ^bus.cand_in;
      1: cand0 = 1'b0;
      2: cand0 = ~(^bus.cand_in);
      3: cand0 = &bus.cand_in;
      default: cand0 = 1'b0;
    endcase
  end
  assign bus.cand_out = cand0;

  // Parity candidates whose output lags their input by one clock
  always @(posedge clk) begin
    d1 <= ^bus1.cand_in;
    d3 <= ^bus3.cand_in;
  end
  assign bus1.cand_out = d1;
  assign bus3.cand_out = d3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      1: return bus1.done;
      3: return bus3.done;
      default: return bus.done;
    endcase
  endfunction

  function automatic logic [3:0] cin_of(input int sel);
    case (sel)
      1: return bus1.cand_in;
      3: return bus3.cand_in;
      default: return bus.cand_in;
    endcase
  endfunction

  function automatic logic [4:0] match_of(input int sel);
    case (sel)
      1: return bus1.match_count;
      3: return bus3.match_count;
      default: return bus.match_count;
    endcase
  endfunction

  function automatic logic perf_of(input int sel);
    case (sel)
      1: return bus1.perfect;
      3: return bus3.perfect;
      default: return bus.perfect;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge just after start was sampled
  task automatic pulse_start(input int sel, input logic [15:0] tt);
    case (sel)
      1: begin bus1.start = 1'b1; bus1.target_tt = tt; end
      3: begin bus3.start = 1'b1; bus3.target_tt = tt; end
      default: begin bus.start = 1'b1; bus.target_tt = tt; end
    endcase
    @(negedge clk);
    bus.start  = 1'b0;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
  endtask

  task automatic await_done(input string tag, input int sel, input int unsigned e0, input int exp_lat);
    int lat;
    lat = -1;
    for (int k = 0; k < exp_lat + 40; k++) begin
      if (done_of(sel)) begin
        lat = int'(cyc - e0);
        break;
      end
      @(negedge clk);
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic check_results(input string tag, input int m, input int f, input int p);
    check_eq({tag, "_match"},   bus.match_count, m);
    check_eq({tag, "_fitness"}, bus.fitness, f);
    check_eq({tag, "_perfect"}, bus.perfect, p);
    check_eq({tag, "_busy_in_done"}, bus.busy, 1);
  endtask

  task automatic run_main(input string tag, input int sel, input logic [15:0] tt,
                          input int m, input int f, input int p);
    int unsigned e0;
    cand_sel = sel;
    pulse_start(0, tt);
    e0 = cyc;
    check_eq({tag, "_busy"}, bus.busy, 1);
    await_done(tag, 0, e0, 48);
    check_results(tag, m, f, p);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, bus.done, 0);
    check_eq({tag, "_busy_after"}, bus.busy, 0);
    check_eq({tag, "_hold"}, bus.match_count, m);
  endtask

  task automatic sweep_delayed(input string tag, input int sel, input int sc);
    int unsigned e0;
    logic [3:0]  last;
    int          runlen, nbad, nchg, lat;
    pulse_start(sel, 16'h6996);
    e0 = cyc;
    last = cin_of(sel);
    runlen = 1; nbad = 0; nchg = 0; lat = -1;
    for (int k = 0; k < 16 * (sc + 1) + 40; k++) begin
      @(negedge clk);
      if (done_of(sel)) begin
        lat = int'(cyc - e0);
        if (runlen != sc + 1) nbad++;
        break;
      end
      if (cin_of(sel) == last) runlen++;
      else begin
        if (runlen != sc + 1 || cin_of(sel) != last + 4'd1) nbad++;
        nchg++;
        last = cin_of(sel);
        runlen = 1;
      end
    end
    check_eq({tag, "_lat"}, lat, 16 * (sc + 1));
    check_eq({tag, "_bad_holds"}, nbad, 0);
    check_eq({tag, "_steps"}, nchg, 15);
    check_eq({tag, "_match"}, match_of(sel), 16);
    check_eq({tag, "_perfect"}, perf_of(sel), 1);
  endtask

  initial begin
    int unsigned e0;
    rst_n = 1'b0;
    bus.start = 1'b0;  bus.target_tt = '0;
    bus1.start = 1'b0; bus1.target_tt = '0;
    bus3.start = 1'b0; bus3.target_tt = '0;
    repeat (3) @(negedge clk);

    check_eq("rst_cand_in", bus.cand_in, 0);
    check_eq("rst_busy",    bus.busy, 0);
    check_eq("rst_done",    bus.done, 0);
    check_eq("rst_match",   bus.match_count, 0);
    check_eq("rst_fitness", bus.fitness, 0);
    check_eq("rst_perfect", bus.perfect, 0);

    // Start in the very first cycle after reset release: XOR4 vs parity
    rst_n = 1'b1;
    cand_sel = 0;
    pulse_start(0, 16'h6996);
    e0 = cyc;
    check_eq("xor_busy", bus.busy, 1);
    await_done("xor", 0, e0, 48);
    check_results("xor", 16, 16, 1);
    @(negedge clk);
    check_eq("xor_done_pulse", bus.done, 0);
    check_eq("xor_busy_after", bus.busy, 0);

    run_main("zero", 1, 16'h6996, 8, 0, 0);
    run_main("xnor", 2, 16'h6996, 0, 0, 0);
    run_main("and4", 3, 16'h6996, 7, 7, 0);
    run_main("zero_vs_zero", 1, 16'h0000, 16, 16, 1);

    // Re-pulse mid-sweep with a new table, then during done; then next cycle
    cand_sel = 0;
    pulse_start(0, 16'h6996);
    e0 = cyc;
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.target_tt = 16'h0000;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("rs_busy_mid", bus.busy, 1);
    await_done("rs", 0, e0, 48);
    check_eq("rs_match", bus.match_count, 16);
    check_eq("rs_fitness", bus.fitness, 16);
    bus.start = 1'b1; bus.target_tt = 16'h6996;
    @(negedge clk);
    check_eq("rs_done_ignored_busy", bus.busy, 0);
    check_eq("rs_done_single", bus.done, 0);
    check_eq("rs_hold", bus.match_count, 16);
    @(negedge clk);
    bus.start = 1'b0;
    e0 = cyc;
    check_eq("rs2_busy", bus.busy, 1);
    check_eq("rs2_clr_match", bus.match_count, 0);
    check_eq("rs2_clr_fitness", bus.fitness, 0);
    check_eq("rs2_clr_perfect", bus.perfect, 0);
    await_done("rs2", 0, e0, 48);
    check_eq("rs2_match", bus.match_count, 16);

    // Asynchronous reset mid-sweep discards the partial run
    @(negedge clk);
    pulse_start(0, 16'h6996);
    repeat (19) @(negedge clk);
    check_eq("ar_pre_cand_in", bus.cand_in, 6);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_cand_in", bus.cand_in, 0);
    check_eq("ar_busy",    bus.busy, 0);
    check_eq("ar_done",    bus.done, 0);
    check_eq("ar_match",   bus.match_count, 0);
    check_eq("ar_fitness", bus.fitness, 0);
    check_eq("ar_perfect", bus.perfect, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(0, 16'h6996);
    e0 = cyc;
    await_done("ar_rerun", 0, e0, 48);
    check_results("ar_rerun", 16, 16, 1);

    @(negedge clk);
    sweep_delayed("sc1", 1, 1);
    @(negedge clk);
    sweep_delayed("sc3", 3, 3);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
